// File: rtl/gpio_mask_arbiter.sv
// Round-robin arbiter that turns one 32-bit masked GPIO update per requester
// into one or two 16-bit masked register writes on a shared write port.
// A requester is acknowledged only after all of its generated writes are accepted.
module gpio_mask_arbiter #(
   parameter int unsigned NumReq         = 4,
   parameter int unsigned AddrWidth      = 12,
   parameter logic [AddrWidth-1:0] OutLowerOffset = 'h14,
   parameter logic [AddrWidth-1:0] OutUpperOffset = 'h18,
   parameter logic [AddrWidth-1:0] OeLowerOffset  = 'h20,
   parameter logic [AddrWidth-1:0] OeUpperOffset  = 'h24,
   localparam int unsigned IdW = (NumReq > 1) ? $clog2(NumReq) : 1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [NumReq-1:0]          req_valid_i,
   input  logic [NumReq-1:0]          req_oe_i,
   input  logic [NumReq-1:0][31:0]    req_mask_i,
   input  logic [NumReq-1:0][31:0]    req_data_i,
   output logic [NumReq-1:0]          req_ready_o,
   output logic                       wr_valid_o,
   input  logic                       wr_ready_i,
   output logic [AddrWidth-1:0]       wr_addr_o,
   output logic [31:0]                wr_data_o,
   output logic                       busy_o,
   output logic [IdW-1:0]             grant_id_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WR_LO = 2'd1,
      WR_HI = 2'd2,
      ACK   = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [IdW-1:0]  rr_ptr_q;
   logic            oe_q;
   logic [31:0]     mask_q, data_q;

   logic            any_valid;
   logic [IdW-1:0]  win_id;
   // Payload used to build the next write: the incoming winner while in IDLE,
   // the latched copy afterwards, so inputs cannot disturb writes in flight.
   logic            cur_oe;
   logic [31:0]     cur_mask, cur_data;

   // Round-robin search upward from rr_ptr with wrap-around.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      any_valid = 1'b0;
      win_id    = '0;
      for (int i = 0; i < int'(NumReq); i++) begin
         if (!any_valid && req_valid_i[(int'(rr_ptr_q) + i) % int'(NumReq)]) begin
            any_valid = 1'b1;
            win_id    = IdW'((int'(rr_ptr_q) + i) % int'(NumReq));
         end
      end
   end

   // Next-state selection; empty halves of the mask are skipped entirely.
   always_comb begin
      state_d  = state_q;
      cur_oe   = oe_q;
      cur_mask = mask_q;
      cur_data = data_q;
      case (state_q)
         IDLE: begin
            if (any_valid) begin
               cur_oe   = req_oe_i[win_id];
               cur_mask = req_mask_i[win_id];
               cur_data = req_data_i[win_id];
               if (cur_mask[15:0] != '0)       state_d = WR_LO;
               else if (cur_mask[31:16] != '0) state_d = WR_HI;
               else                            state_d = ACK;
            end
         end
         WR_LO: begin
            if (wr_ready_i) state_d = (mask_q[31:16] != '0) ? WR_HI : ACK;
         end
         WR_HI: begin
            if (wr_ready_i) state_d = ACK;
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Status outputs decoded straight from the state register.
   always_comb begin
      req_ready_o = '0;
      if (state_q == ACK) req_ready_o[grant_id_o] = 1'b1;
      wr_valid_o = (state_q == WR_LO) || (state_q == WR_HI);
      busy_o     = (state_q != IDLE);
   end

   // State, payload, pointer and registered write bus; address/data load only on
   // entry to a write state so they hold steady under backpressure.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         oe_q       <= 1'b0;
         mask_q     <= '0;
         data_q     <= '0;
         grant_id_o <= '0;
         wr_addr_o  <= '0;
         wr_data_o  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         state_q <= state_d;
         if (state_q == IDLE && any_valid) begin
            oe_q       <= cur_oe;
            mask_q     <= cur_mask;
            data_q     <= cur_data;
            grant_id_o <= win_id;
         end
         if (state_q == ACK) begin
            rr_ptr_q <= IdW'((int'(grant_id_o) + 1) % int'(NumReq));
         end
         if (state_d == WR_LO && state_q != WR_LO) begin
            wr_addr_o <= cur_oe ? OeLowerOffset : OutLowerOffset;
            wr_data_o <= {cur_mask[15:0], cur_data[15:0]};
         end else if (state_d == WR_HI && state_q != WR_HI) begin
            wr_addr_o <= cur_oe ? OeUpperOffset : OutUpperOffset;
            wr_data_o <= {cur_mask[31:16], cur_data[31:16]};
         end
      end
   end

endmodule

// File: tb/tb_gpio_mask_arbiter.sv
// Self-checking bench for gpio_mask_arbiter: table-driven single requests,
// plus hand-written fairness, backpressure and mid-service reset sequences.
// Expected writes go into a scoreboard queue and are popped on each handshake.
module tb_gpio_mask_arbiter;

   localparam int N = 4;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b1;
   logic [N-1:0]      req_valid = '0;
   logic [N-1:0]      req_oe = '0;
   logic [N-1:0][31:0] req_mask = '0;
   logic [N-1:0][31:0] req_data = '0;
   logic [N-1:0]      req_ready_o;
   logic              wr_valid_o;
   logic              wr_ready = 1'b1;
   logic [11:0]       wr_addr_o;
   logic [31:0]       wr_data_o;
   logic              busy_o;
   logic [1:0]        grant_id_o;

   gpio_mask_arbiter #(.NumReq(N)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_valid_i (req_valid),
      .req_oe_i    (req_oe),
      .req_mask_i  (req_mask),
      .req_data_i  (req_data),
      .req_ready_o (req_ready_o),
      .wr_valid_o  (wr_valid_o),
      .wr_ready_i  (wr_ready),
      .wr_addr_o   (wr_addr_o),
      .wr_data_o   (wr_data_o),
      .busy_o      (busy_o),
      .grant_id_o  (grant_id_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [11:0] addr;
      logic [31:0] data;
   } exp_wr_t;

   typedef struct {
      int          id;
      logic        oe;
      logic [31:0] mask;
      logic [31:0] data;
      int          nwr;
      logic [11:0] a0;
      logic [31:0] d0;
      logic [11:0] a1;
      logic [31:0] d1;
      int          ack_cyc;
   } vec_t;

   exp_wr_t sb[$];
   int n_vec  = 0;
   int n_miss = 0;
   int wr_seen = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model of the write split for one request.
   task automatic push_req(input logic oe, input logic [31:0] mask, input logic [31:0] data);
      if (mask[15:0] != 16'h0)  sb.push_back('{oe ? 12'h020 : 12'h014, {mask[15:0], data[15:0]}});
      if (mask[31:16] != 16'h0) sb.push_back('{oe ? 12'h024 : 12'h018, {mask[31:16], data[31:16]}});
   endtask

   // Scoreboard pop on every accepted write, plus hold checks under backpressure.
   logic        stall_prev = 1'b0;
   logic [11:0] prev_addr = '0;
   logic [31:0] prev_data = '0;
   always @(negedge clk_i) begin
      if (rst_i) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("stall_valid_held", wr_valid_o, 1);
            check("stall_addr_stable", wr_addr_o, prev_addr);
            check("stall_data_stable", wr_data_o, prev_data);
         end
         if (wr_valid_o && wr_ready) begin
            exp_wr_t e;
            wr_seen++;
            check("wr_expected", 64'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("wr_addr", wr_addr_o, e.addr);
               check("wr_data", wr_data_o, e.data);
            end
         end
         stall_prev = wr_valid_o && !wr_ready;
         prev_addr  = wr_addr_o;
         prev_data  = wr_data_o;
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_wr_valid"}, wr_valid_o, 0);
      check({tag, "_wr_addr"}, wr_addr_o, 0);
      check({tag, "_wr_data"}, wr_data_o, 0);
      check({tag, "_req_ready"}, req_ready_o, 0);
      check({tag, "_busy"}, busy_o, 0);
      check({tag, "_grant_id"}, grant_id_o, 0);
   endtask

   task automatic do_reset();
      req_valid = '0;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
   endtask

   // Drive one request (called just after a rising edge = start of cycle 1) and
   // run until its acknowledge; the write port stalls for 'stall' cycles first.
   task automatic run_req(input int id, input logic oe, input logic [31:0] mask,
                          input logic [31:0] data, input int stall,
                          output int ack_cyc, output int first_wr);
      int stalls;
      bit got;
      stalls = 0; got = 0; ack_cyc = 0; first_wr = 0;
      req_valid[id] = 1'b1;
      req_oe[id]    = oe;
      req_mask[id]  = mask;
      req_data[id]  = data;
      wr_ready      = (stall == 0);
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk_i);
         if (wr_valid_o && first_wr == 0) first_wr = cyc;
         if (wr_valid_o && !wr_ready) stalls++;
         if (cyc == 2) begin
            check("grant_id", grant_id_o, id);
            check("busy_in_service", busy_o, 1);
         end
         if (req_ready_o != '0) begin
            got = 1;
            ack_cyc = cyc;
            check("ack_vector", req_ready_o, 64'(1) << id);
         end
         @(posedge clk_i); #1;
         if (stalls >= stall) wr_ready = 1'b1;
         if (got) begin
            req_valid[id] = 1'b0;
            break;
         end
      end
      if (!got) check("ack_timeout", 0, 1);
   endtask

   vec_t vecs[6];

   initial begin
      int ack, fw, w0;
      vecs[0] = '{0, 1'b0, 32'hFFFF_FFFF, 32'hA5A5_1234, 2, 12'h014, 32'hFFFF_1234, 12'h018, 32'hFFFF_A5A5, 4};
      vecs[1] = '{2, 1'b1, 32'h00F0_0000, 32'h0030_0000, 1, 12'h024, 32'h00F0_0030, 12'h000, 32'h0, 3};
      vecs[2] = '{1, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 0, 12'h000, 32'h0, 12'h000, 32'h0, 2};
      vecs[3] = '{3, 1'b1, 32'h0000_00FF, 32'h1234_5678, 1, 12'h020, 32'h00FF_5678, 12'h000, 32'h0, 3};
      vecs[4] = '{1, 1'b1, 32'hFFFF_0001, 32'hFFFF_FFFF, 2, 12'h020, 32'h0001_FFFF, 12'h024, 32'hFFFF_FFFF, 4};
      vecs[5] = '{0, 1'b0, 32'h8000_0000, 32'h0000_0000, 1, 12'h018, 32'h8000_0000, 12'h000, 32'h0, 3};

      // Reset state.
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check_reset_outputs("reset");
      @(posedge clk_i); #1;
      rst_i = 1'b0;

      // Table-driven single requests.
      foreach (vecs[i]) begin
         if (vecs[i].nwr >= 1) sb.push_back('{vecs[i].a0, vecs[i].d0});
         if (vecs[i].nwr == 2) sb.push_back('{vecs[i].a1, vecs[i].d1});
         w0 = wr_seen;
         run_req(vecs[i].id, vecs[i].oe, vecs[i].mask, vecs[i].data, 0, ack, fw);
         check($sformatf("v%0d_ack_cycle", i), ack, vecs[i].ack_cyc);
         check($sformatf("v%0d_write_count", i), wr_seen - w0, vecs[i].nwr);
         if (vecs[i].nwr > 0) check($sformatf("v%0d_first_write_cycle", i), fw, 2);
         check($sformatf("v%0d_sb_drained", i), sb.size(), 0);
      end

      // Backpressure: three stalled cycles in WR_LO delay the ACK by three.
      push_req(1'b0, 32'hFFFF_FFFF, 32'hC0DE_7777);
      run_req(0, 1'b0, 32'hFFFF_FFFF, 32'hC0DE_7777, 3, ack, fw);
      check("stall_ack_cycle", ack, 7);
      check("stall_first_write_cycle", fw, 2);

      // Fairness: all four held valid with full masks, starting from rr_ptr=0.
      do_reset();
      begin
         int order[6] = '{0, 1, 2, 3, 0, 1};
         int n, last, id;
         bit done;
         n = 0; last = 0; done = 0;
         foreach (order[k]) push_req(1'b0, 32'hFFFF_FFFF, {16'hA000 + 16'(order[k]), 16'h5000 + 16'(order[k])});
         for (int k = 0; k < N; k++) begin
            req_oe[k]   = 1'b0;
            req_mask[k] = 32'hFFFF_FFFF;
            req_data[k] = {16'hA000 + 16'(k), 16'h5000 + 16'(k)};
         end
         req_valid = '1;
         for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(negedge clk_i);
            if (req_ready_o != '0) begin
               id = 0;
               for (int k = 0; k < N; k++) if (req_ready_o[k]) id = k;
               check("fair_ack_onehot", $countones(req_ready_o), 1);
               check($sformatf("fair_grant_%0d", n), id, order[n]);
               check($sformatf("fair_ack_cycle_%0d", n), cyc - last, 4);
               last = cyc;
               n++;
            end
            @(posedge clk_i); #1;
            if (n == 6) begin
               req_valid = '0;
               done = 1;
            end
         end
         check("fair_ack_count", n, 6);
         check("fair_sb_drained", sb.size(), 0);
      end

      // Reset while in WR_HI: no ACK, outputs cleared, request re-served from scratch.
      do_reset();
      push_req(1'b1, 32'h0000_FFFF, 32'h0BAD_F00D);       // lower write before reset
      push_req(1'b1, 32'hFFFF_FFFF, 32'h0BAD_F00D);       // full re-service
      req_valid[3] = 1'b1;
      req_oe[3]    = 1'b1;
      req_mask[3]  = 32'hFFFF_FFFF;
      req_data[3]  = 32'h0BAD_F00D;
      wr_ready     = 1'b1;
      @(posedge clk_i); #1;                               // cycle 2: WR_LO
      @(negedge clk_i);
      check("rst_seq_lo_valid", wr_valid_o, 1);
      check("rst_seq_no_ack_lo", req_ready_o, 0);
      @(posedge clk_i); #1;                               // cycle 3: WR_HI
      rst_i = 1'b1;
      wr_ready = 1'b0;
      @(negedge clk_i);
      check("rst_seq_in_wr_hi_addr", wr_addr_o, 12'h024);
      check("rst_seq_no_ack_hi", req_ready_o, 0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      wr_ready = 1'b1;
      check_reset_outputs("mid_reset");
      w0 = wr_seen;
      run_req(3, 1'b1, 32'hFFFF_FFFF, 32'h0BAD_F00D, 0, ack, fw);
      check("rst_reserve_ack_cycle", ack, 4);
      check("rst_reserve_write_count", wr_seen - w0, 2);
      check("final_sb_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
